// File: rtl/fixed_float_converter_pipe_pkg.sv
// ---------------------------------------------------------------------------
// fixed_float_pkg
//   Shared constants, operand classification type and the rounding helper
//   for the fixed-point <-> IEEE-754 single-precision converter pipeline.
// ---------------------------------------------------------------------------
package fixed_float_pkg;

    localparam int   FLT_BIAS     = 127;
    localparam int   EXP_W        = 8;
    localparam int   MAN_W        = 23;

    localparam logic OP_FLT2FIX   = 1'b1;
    localparam logic OP_FIX2FLT   = 1'b0;

    localparam int   FLG_INEXACT  = 0;
    localparam int   FLG_OVERFLOW = 1;
    localparam int   FLG_INVALID  = 2;

    localparam int   RND_TRUNC    = 0;
    localparam int   RND_RNE      = 1;

    // float->fixed alignment field: 40 integer bits above 40 fraction bits.
    // The 24-bit significand is shifted left by (exp + pos - SA_OFS); shifts
    // above SA_MAX can only saturate, negative shifts leave only sticky bits.
    localparam int   WIDE_FRAC    = 40;
    localparam int   WIDE_W       = 2 * WIDE_FRAC;
    localparam int   SA_OFS       = FLT_BIAS + MAN_W - WIDE_FRAC;
    localparam int   SA_MAX       = 49;

    typedef enum logic [2:0] {
        CLS_NORM = 3'd0,   // ordinary value, goes through shift/round
        CLS_ZERO = 3'd1,   // exact zero
        CLS_NAN  = 3'd2,
        CLS_INF  = 3'd3,
        CLS_BIG  = 3'd4,   // magnitude certainly beyond any fixed range
        CLS_TINY = 3'd5    // denormal or magnitude below half an LSB: 0, inexact
    } cls_e;

    // Decide whether the kept value must be incremented by one LSB.
    function automatic logic round_up(input int mode, input logic lsb,
                                      input logic guard, input logic sticky);
        if (mode == RND_RNE) begin
            return guard & (sticky | lsb);
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/fixed_float_converter_pipe_lod.sv
// ---------------------------------------------------------------------------
// leading_one_detector
//   Combinational index of the most significant set bit.
//   Ports: data    - input word
//          msb_idx - index of highest '1' (0 when data is zero)
//          zero    - data is all zeros
// ---------------------------------------------------------------------------
module leading_one_detector #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         data,
    output logic [$clog2(WIDTH)-1:0] msb_idx,
    output logic                     zero
);

    localparam int IDX_W = $clog2(WIDTH);

    // Priority scan from LSB upward so the last hit is the most significant one
    always_comb begin
        msb_idx = '0;
        zero    = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                msb_idx = IDX_W'(i);
                zero    = 1'b0;
            end else begin
                msb_idx = msb_idx;
                zero    = zero;
            end
        end
    end

endmodule

// File: rtl/fixed_float_converter_pipe.sv
// ---------------------------------------------------------------------------
// fixed_float_converter_pipe
//   Three-stage bidirectional fixed-point <-> IEEE-754 single converter with
//   valid/ready flow control. S1 unpack/classify, S2 leading-one detect and
//   barrel shift, S3 round/pack/saturate into the output registers.
//   Ports: clk, rst (async, active low)
//          in_valid/in_ready, opcode (1 = float->fixed), fixpointpos,
//          targetnumber            - operand side
//          out_valid/out_ready, result, flags {invalid, overflow, inexact}
//                                  - result side
// ---------------------------------------------------------------------------
module fixed_float_converter_pipe
    import fixed_float_pkg::*;
#(
    parameter int FIX_W    = 32,
    parameter int POS_W    = 5,
    parameter int RND_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             opcode,
    input  logic [POS_W-1:0] fixpointpos,
    input  logic [31:0]      targetnumber,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [2:0]       flags
);

    localparam logic [40:0] POS_LIM = (41'd1 << (FIX_W - 1)) - 41'd1;
    localparam logic [40:0] NEG_LIM = (41'd1 << (FIX_W - 1));
    localparam logic [31:0] SAT_POS = POS_LIM[31:0];
    localparam logic [31:0] SAT_NEG = ~SAT_POS;

    // ---------------- flow control ----------------
    logic advance_s;
    logic s1_valid_r, s2_valid_r, out_valid_r;
    logic [31:0] result_r;
    logic [2:0]  flags_r;

    assign advance_s = ~out_valid_r | out_ready;
    assign in_ready  = advance_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flags     = flags_r;

    // ---------------- S1: unpack / classify ----------------
    logic [FIX_W-1:0] fix_val_s, fix_neg_s;
    logic [EXP_W-1:0] f_exp_s;
    logic [MAN_W-1:0] f_man_s;
    logic [10:0]      sa_s;
    logic             s1_sign_s;
    logic [31:0]      s1_mag_s;
    cls_e             s1_cls_s;

    logic             s1_op_r, s1_sign_r;
    logic [POS_W-1:0] s1_pos_r;
    logic [31:0]      s1_mag_r;
    logic [5:0]       s1_sa_r;
    cls_e             s1_cls_r;

    // Split operand into sign/magnitude and classify float specials
    always_comb begin
        fix_val_s = targetnumber[FIX_W-1:0];
        fix_neg_s = ~fix_val_s + FIX_W'(1'b1);
        f_exp_s   = targetnumber[30:23];
        f_man_s   = targetnumber[22:0];
        sa_s      = 11'(f_exp_s) + 11'(fixpointpos) - 11'(SA_OFS);
        s1_sign_s = 1'b0;
        s1_mag_s  = 32'd0;
        s1_cls_s  = CLS_NORM;
        if (opcode == OP_FIX2FLT) begin
            // two's-complement negate also yields 2^(FIX_W-1) for the most negative input
            s1_sign_s = fix_val_s[FIX_W-1];
            s1_mag_s  = fix_val_s[FIX_W-1] ? 32'(fix_neg_s) : 32'(fix_val_s);
            s1_cls_s  = CLS_NORM;
        end else begin
            s1_sign_s = targetnumber[31];
            s1_mag_s  = {8'd0, 1'b1, f_man_s};
            if (f_exp_s == 8'hFF) begin
                s1_cls_s = (f_man_s != 23'd0) ? CLS_NAN : CLS_INF;
            end else if (f_exp_s == 8'h00) begin
                s1_cls_s = (f_man_s != 23'd0) ? CLS_TINY : CLS_ZERO;
            end else if (sa_s[10]) begin
                s1_cls_s = CLS_TINY;
            end else if (sa_s > 11'(SA_MAX)) begin
                s1_cls_s = CLS_BIG;
            end else begin
                s1_cls_s = CLS_NORM;
            end
        end
    end

    // S1 operand registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_op_r   <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_pos_r  <= '0;
            s1_mag_r  <= 32'd0;
            s1_sa_r   <= 6'd0;
            s1_cls_r  <= CLS_NORM;
        end else if (advance_s) begin
            s1_op_r   <= opcode;
            s1_sign_r <= s1_sign_s;
            s1_pos_r  <= fixpointpos;
            s1_mag_r  <= s1_mag_s;
            s1_sa_r   <= sa_s[5:0];
            s1_cls_r  <= s1_cls_s;
        end else begin
            s1_op_r   <= s1_op_r;
            s1_sign_r <= s1_sign_r;
            s1_pos_r  <= s1_pos_r;
            s1_mag_r  <= s1_mag_r;
            s1_sa_r   <= s1_sa_r;
            s1_cls_r  <= s1_cls_r;
        end
    end

    // ---------------- S2: leading-one detect + barrel shift ----------------
    logic [$clog2(FIX_W)-1:0] lod_idx_s;
    logic                     lod_zero_s;
    logic [5:0]               sh_fix_s;
    logic [31:0]              norm_s;
    logic [WIDE_W-1:0]        wide_s;
    logic [39:0]              s2_hi_s;
    logic                     s2_g_s, s2_st_s;
    cls_e                     s2_cls_s;

    logic                     s2_op_r, s2_sign_r, s2_g_r, s2_st_r;
    logic [39:0]              s2_hi_r;
    logic [EXP_W-1:0]         s2_exp_r;
    cls_e                     s2_cls_r;

    leading_one_detector #(.WIDTH(FIX_W)) u_lod (
        .data    (s1_mag_r[FIX_W-1:0]),
        .msb_idx (lod_idx_s),
        .zero    (lod_zero_s)
    );

    // Normalise (fixed->float) or align (float->fixed) and split kept/guard/sticky bits
    always_comb begin
        sh_fix_s = 6'd31 - 6'(lod_idx_s);
        norm_s   = s1_mag_r << sh_fix_s;
        wide_s   = WIDE_W'(s1_mag_r[23:0]) << s1_sa_r;
        s2_hi_s  = 40'd0;
        s2_g_s   = 1'b0;
        s2_st_s  = 1'b0;
        s2_cls_s = s1_cls_r;
        if (s1_op_r == OP_FIX2FLT) begin
            // hidden bit lands in s2_hi_s[23], mantissa in [22:0]
            s2_hi_s  = {16'd0, norm_s[31:8]};
            s2_g_s   = norm_s[7];
            s2_st_s  = |norm_s[6:0];
            s2_cls_s = lod_zero_s ? CLS_ZERO : CLS_NORM;
        end else begin
            s2_hi_s  = wide_s[WIDE_W-1:WIDE_FRAC];
            s2_g_s   = wide_s[WIDE_FRAC-1];
            s2_st_s  = |wide_s[WIDE_FRAC-2:0];
            s2_cls_s = s1_cls_r;
        end
    end

    // S2 shifted-operand registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_op_r   <= 1'b0;
            s2_sign_r <= 1'b0;
            s2_g_r    <= 1'b0;
            s2_st_r   <= 1'b0;
            s2_hi_r   <= 40'd0;
            s2_exp_r  <= 8'd0;
            s2_cls_r  <= CLS_NORM;
        end else if (advance_s) begin
            s2_op_r   <= s1_op_r;
            s2_sign_r <= s1_sign_r;
            s2_g_r    <= s2_g_s;
            s2_st_r   <= s2_st_s;
            s2_hi_r   <= s2_hi_s;
            // always in 96..158, so modular 8-bit arithmetic is exact
            s2_exp_r  <= 8'(FLT_BIAS) + 8'(lod_idx_s) - 8'(s1_pos_r);
            s2_cls_r  <= s2_cls_s;
        end else begin
            s2_op_r   <= s2_op_r;
            s2_sign_r <= s2_sign_r;
            s2_g_r    <= s2_g_r;
            s2_st_r   <= s2_st_r;
            s2_hi_r   <= s2_hi_r;
            s2_exp_r  <= s2_exp_r;
            s2_cls_r  <= s2_cls_r;
        end
    end

    // ---------------- S3: round / pack / saturate ----------------
    logic        ru_s;
    logic [30:0] body_s;
    logic [40:0] mag_s;
    logic        ovf_s;
    logic [31:0] result_s;
    logic [2:0]  flags_s;

    // Round, then pack the float or range-check and saturate the fixed result
    always_comb begin
        ru_s     = round_up(RND_MODE, s2_hi_r[0], s2_g_r, s2_st_r);
        // mantissa carry-out propagates straight into the exponent field
        body_s   = {s2_exp_r, s2_hi_r[22:0]} + 31'(ru_s);
        mag_s    = {1'b0, s2_hi_r} + 41'(ru_s);
        ovf_s    = s2_sign_r ? (mag_s > NEG_LIM) : (mag_s > POS_LIM);
        result_s = 32'd0;
        flags_s  = 3'b000;
        if (s2_op_r == OP_FIX2FLT) begin
            if (s2_cls_r == CLS_ZERO) begin
                result_s = 32'd0;
            end else begin
                result_s               = {s2_sign_r, body_s};
                flags_s[FLG_INEXACT]   = s2_g_r | s2_st_r;
            end
        end else begin
            case (s2_cls_r)
                CLS_NAN: begin
                    flags_s[FLG_INVALID]  = 1'b1;
                end
                CLS_INF, CLS_BIG: begin
                    result_s              = s2_sign_r ? SAT_NEG : SAT_POS;
                    flags_s[FLG_OVERFLOW] = 1'b1;
                end
                CLS_TINY: begin
                    flags_s[FLG_INEXACT]  = 1'b1;
                end
                CLS_NORM: begin
                    flags_s[FLG_INEXACT]  = s2_g_r | s2_st_r;
                    if (ovf_s) begin
                        result_s              = s2_sign_r ? SAT_NEG : SAT_POS;
                        flags_s[FLG_OVERFLOW] = 1'b1;
                    end else begin
                        result_s = s2_sign_r ? (32'd0 - mag_s[31:0]) : mag_s[31:0];
                    end
                end
                default: begin
                    result_s = 32'd0;
                end
            endcase
        end
    end

    // Stage valids and output holding registers; everything freezes on stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r  <= 1'b0;
            s2_valid_r  <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= 32'd0;
            flags_r     <= 3'b000;
        end else if (advance_s) begin
            s1_valid_r  <= in_valid;
            s2_valid_r  <= s1_valid_r;
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                result_r <= result_s;
                flags_r  <= flags_s;
            end else begin
                result_r <= result_r;
                flags_r  <= flags_r;
            end
        end else begin
            s1_valid_r  <= s1_valid_r;
            s2_valid_r  <= s2_valid_r;
            out_valid_r <= out_valid_r;
            result_r    <= result_r;
            flags_r     <= flags_r;
        end
    end

endmodule

// File: tb/tb_fixed_float_converter_pipe.sv
// ---------------------------------------------------------------------------
// tb_fixed_float_converter_pipe
//   Directed bench for fixed_float_converter_pipe. Two instances share all
//   inputs: one rounds to nearest-even, the other truncates.
// ---------------------------------------------------------------------------
module tb_fixed_float_converter_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, opcode;
    logic [4:0]  fixpointpos;
    logic [31:0] targetnumber;
    logic        in_ready, out_valid;
    logic [31:0] result;
    logic [2:0]  flags;
    logic        in_ready_t, out_valid_t;
    logic [31:0] result_t;
    logic [2:0]  flags_t;

    int n_checks = 0;
    int n_fail   = 0;

    fixed_float_converter_pipe #(.FIX_W(32), .POS_W(5), .RND_MODE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .fixpointpos(fixpointpos), .targetnumber(targetnumber),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    fixed_float_converter_pipe #(.FIX_W(32), .POS_W(5), .RND_MODE(0)) u_dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .opcode(opcode), .fixpointpos(fixpointpos), .targetnumber(targetnumber),
        .out_valid(out_valid_t), .out_ready(out_ready), .result(result_t), .flags(flags_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One operand through an empty pipe; checks 3-cycle latency and both results.
    task automatic run_one(input string tag, input logic op, input logic [4:0] pos,
                           input logic [31:0] val,
                           input logic [31:0] er,  input logic [2:0] ef,
                           input logic [31:0] er0, input logic [2:0] ef0);
        @(negedge clk);
        opcode = op; fixpointpos = pos; targetnumber = val;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"},       32'(out_valid), 32'd1);
        chk({tag, "_result"},      result,         er);
        chk({tag, "_flags"},       32'(flags),     32'(ef));
        chk({tag, "_trunc_result"}, result_t,      er0);
        chk({tag, "_trunc_flags"}, 32'(flags_t),   32'(ef0));
    endtask

    logic [31:0] exp5 [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    initial begin
        int          sent, recv;
        logic        stalled, rdy;
        logic [31:0] held;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 1'b0; fixpointpos = 5'd0; targetnumber = 32'd0;

        // reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    result,         32'd0);
        chk("rst_flags",     32'(flags),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

        // directed conversions: tag, op, pos, operand, RNE result/flags, trunc result/flags
        run_one("fx2fl_3p0",    1'b0, 5'd3,  32'h00000018, 32'h40400000, 3'b000, 32'h40400000, 3'b000);
        run_one("fl2fx_m1p5",   1'b1, 5'd4,  32'hBFC00000, 32'hFFFFFFE8, 3'b000, 32'hFFFFFFE8, 3'b000);
        run_one("fx2fl_round",  1'b0, 5'd0,  32'h01000003, 32'h4B800002, 3'b001, 32'h4B800001, 3'b001);
        run_one("fx2fl_carry",  1'b0, 5'd0,  32'h01FFFFFF, 32'h4C000000, 3'b001, 32'h4BFFFFFF, 3'b001);
        run_one("fl2fx_2p32",   1'b1, 5'd0,  32'h4F800000, 32'h7FFFFFFF, 3'b010, 32'h7FFFFFFF, 3'b010);
        run_one("fl2fx_2p31",   1'b1, 5'd0,  32'h4F000000, 32'h7FFFFFFF, 3'b010, 32'h7FFFFFFF, 3'b010);
        run_one("fl2fx_m2p31",  1'b1, 5'd0,  32'hCF000000, 32'h80000000, 3'b000, 32'h80000000, 3'b000);
        run_one("fl2fx_nan",    1'b1, 5'd0,  32'h7FC00000, 32'h00000000, 3'b100, 32'h00000000, 3'b100);
        run_one("fl2fx_minf",   1'b1, 5'd0,  32'hFF800000, 32'h80000000, 3'b010, 32'h80000000, 3'b010);
        run_one("fl2fx_3p5",    1'b1, 5'd0,  32'h40600000, 32'h00000004, 3'b001, 32'h00000003, 3'b001);
        run_one("fl2fx_half",   1'b1, 5'd0,  32'h3F000000, 32'h00000000, 3'b001, 32'h00000000, 3'b001);
        run_one("fl2fx_denorm", 1'b1, 5'd0,  32'h00000001, 32'h00000000, 3'b001, 32'h00000000, 3'b001);
        run_one("fx2fl_zero",   1'b0, 5'd0,  32'h00000000, 32'h00000000, 3'b000, 32'h00000000, 3'b000);
        run_one("fx2fl_mostneg",1'b0, 5'd0,  32'h80000000, 32'hCF000000, 3'b000, 32'hCF000000, 3'b000);
        run_one("fx2fl_neg",    1'b0, 5'd4,  32'hFFFFFFE8, 32'hBFC00000, 3'b000, 32'hBFC00000, 3'b000);
        run_one("fx2fl_pos31",  1'b0, 5'd31, 32'h00000001, 32'h30000000, 3'b000, 32'h30000000, 3'b000);

        // back-to-back stream with out_ready toggling every cycle
        sent = 0; recv = 0; stalled = 1'b0; rdy = 1'b0; held = 32'd0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge clk);
            rdy = ~rdy;
            out_ready = rdy;
            in_valid = (sent < 8);
            opcode = 1'b0; fixpointpos = 5'd0;
            targetnumber = 32'(sent + 1);
            #1;
            if (stalled) begin
                chk("t5_stall_valid", 32'(out_valid), 32'd1);
                chk("t5_stall_hold",  result,         held);
            end
            if (out_valid && out_ready) begin
                if (recv < 8) begin
                    chk("t5_result", result,     exp5[recv]);
                    chk("t5_flags",  32'(flags), 32'd0);
                end else begin
                    chk("t5_no_extra", 32'(out_valid), 32'd0);
                end
                recv++;
            end
            if (out_valid && !out_ready) begin
                chk("t5_in_ready_stall", 32'(in_ready), 32'd0);
                held = result;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (in_valid && in_ready) sent++;
        end
        chk("t5_recv_count", 32'(recv), 32'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_dup", 32'(out_valid), 32'd0);
        end

        // reset with three operands in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1; opcode = 1'b0; fixpointpos = 5'd0;
            targetnumber = 32'(i + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_inflight", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid",  32'(out_valid), 32'd0);
        chk("t6_rst_result", result,         32'd0);
        chk("t6_rst_flags",  32'(flags),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("t6_rel_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_emit", 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
